// File: rtl/i2s_tx_pkg.sv
// I2S transmitter shared types and frame constants.
// Imported by the bus interface, bit clock generator and top.
package i2s_tx_pkg;

  localparam int SLOT_WIDTH   = 32;
  localparam int FRAME_BITS   = 64;
  localparam int REQ_BIT      = 48;
  localparam int LRCK_R_START = 31;
  localparam int LRCK_R_END   = 62;
  localparam int BIT_CNT_W    = $clog2(FRAME_BITS);

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef struct packed {
    logic [SLOT_WIDTH-1:0] left;
    logic [SLOT_WIDTH-1:0] right;
  } stereo_t;

  // Keep the top dw bits of a slot, zero the pad below them.
  function automatic logic [SLOT_WIDTH-1:0] slot_pad(
    input logic [SLOT_WIDTH-1:0] s,
    input int                    dw
  );
    logic [SLOT_WIDTH-1:0] ones;
    ones = '1;
    return s & ~(ones >> dw);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample fetch + I2S bus bundle of the transmitter.
// master: transmitter side; slave: buffer/codec side.
interface i2s_tx_if;
  import i2s_tx_pkg::*;

  logic                  sample_req;
  logic [SLOT_WIDTH-1:0] left_channel;
  logic [SLOT_WIDTH-1:0] right_channel;
  logic                  i2s_bclk;
  logic                  i2s_lrck;
  logic                  i2s_sdata;

  modport master (
    output sample_req,
    output i2s_bclk,
    output i2s_lrck,
    output i2s_sdata,
    input  left_channel,
    input  right_channel
  );

  modport slave (
    input  sample_req,
    input  i2s_bclk,
    input  i2s_lrck,
    input  i2s_sdata,
    output left_channel,
    output right_channel
  );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider: bclk toggles every CLK_DIV clk cycles.
// Ports: clk, nrst, enable in; bclk, rise, fall strobes out.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic enable,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;
  logic          bclk_q;
  logic          bclk_d;
  logic          tc;

  assign tc = (div_cnt_q == TC);

  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!enable) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (tc) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // Strobes mark the edge on which bclk is about to change.
  assign rise = enable & tc & ~bclk_q;
  assign fall = enable & tc &  bclk_q;
  assign bclk = bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S master transmitter, 64-bit stereo frames.
// Ports: clk, nrst, enable; bus (master): sample fetch + I2S.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     nrst,
  input  logic     enable,
  i2s_tx_if.master bus
);

  logic bclk;
  logic rise;
  logic fall;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk (
    .clk    (clk),
    .nrst   (nrst),
    .enable (enable),
    .bclk   (bclk),
    .rise   (rise),
    .fall   (fall)
  );

  bit_cnt_t                  bit_cnt_q;
  bit_cnt_t                  bit_cnt_d;
  bit_cnt_t                  bit_nxt;
  logic [2*SLOT_WIDTH-1:0]   shreg_q;
  logic [2*SLOT_WIDTH-1:0]   shreg_d;
  stereo_t                   hold_q;
  stereo_t                   hold_d;
  logic                      lrck_q;
  logic                      lrck_d;
  logic                      sdata_q;
  logic                      sdata_d;
  logic                      req_q;
  logic                      req_d;

  assign bit_nxt = bit_cnt_q + 1'b1;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    req_d     = 1'b0;
    if (!enable) begin
      bit_cnt_d = '1;
      shreg_d   = '0;
      hold_d    = '0;
      lrck_d    = 1'b0;
      sdata_d   = 1'b0;
    end else begin
      // Buffer output is valid only while req_q is high.
      if (req_q) begin
        hold_d.left  = bus.left_channel;
        hold_d.right = bus.right_channel;
      end
      if (fall) begin
        bit_cnt_d = bit_nxt;
        if (bit_nxt == '0) begin
          shreg_d = {
            slot_pad(hold_q.left,  DATA_WIDTH),
            slot_pad(hold_q.right, DATA_WIDTH)
          };
        end else begin
          shreg_d = shreg_q << 1;
        end
        sdata_d = shreg_d[2*SLOT_WIDTH-1];
        // LRCK leads each slot MSB by one bit.
        lrck_d  =
          (bit_nxt >= BIT_CNT_W'(LRCK_R_START)) &&
          (bit_nxt <= BIT_CNT_W'(LRCK_R_END));
        req_d   = (bit_nxt == BIT_CNT_W'(REQ_BIT));
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt_q <= '1;
      shreg_q   <= '0;
      hold_q    <= '0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
    end
  end

  assign bus.sample_req = req_q;
  assign bus.i2s_bclk   = bclk;
  assign bus.i2s_lrck   = lrck_q;
  assign bus.i2s_sdata  = sdata_q;

endmodule
